// File: rtl/uart_tx_pacer_pkg.sv
// Shared definitions for the UART transmit pacer: default gap, grant and state encodings,
// and the round-robin grant helper.
package uart_tx_pacer_pkg;

  localparam int unsigned DUMPWAIT = 32'h0000_0fff;

  typedef enum logic {
    GNT_MON  = 1'b0,
    GNT_FIFO = 1'b1
  } grant_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_GAP  = 1'b1
  } pacer_state_e;

  // A tie goes to whichever source did not win last time, so neither side can starve.
  function automatic grant_e pick_grant(input logic mon_pend, input logic fifo_pend,
                                        input grant_e last);
    if (mon_pend && fifo_pend) begin
      return (last == GNT_MON) ? GNT_FIFO : GNT_MON;
    end else if (mon_pend) begin
      return GNT_MON;
    end
    return GNT_FIFO;
  endfunction

endpackage

// File: rtl/uart_tx_pacer.sv
// Sole driver of the UART transmitter: merges monitor bytes and the CPU output FIFO into
// one stream, with a fixed idle gap after every launch.
module uart_tx_pacer
  import uart_tx_pacer_pkg::*;
#(
  parameter int unsigned GAP_CYCLES = DUMPWAIT,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                 CLK,
  input  logic                 reset,
  input  logic                 mon_valid,
  input  logic [7:0]           mon_byte,
  output logic                 mon_ready,
  input  logic                 fifo_en,
  input  logic                 fifo_empty,
  input  logic [7:0]           fifo_data,
  output logic                 fifo_read,
  input  logic                 u_is_transmitting,
  output logic                 u_transmit,
  output logic [7:0]           u_tx_byte,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] tx_count
);

  localparam logic [CNT_WIDTH-1:0] GAP_LOAD = CNT_WIDTH'(GAP_CYCLES);

  pacer_state_e         state_q, state_d;
  grant_e               last_grant_q, last_grant_d;
  logic [CNT_WIDTH-1:0] gap_q, gap_d;
  logic [CNT_WIDTH-1:0] tx_count_q, tx_count_d;
  logic [7:0]           tx_byte_q, tx_byte_d;
  logic                 transmit_q, transmit_d;
  logic                 fifo_read_q, fifo_read_d;

  logic   mon_pend;
  logic   fifo_pend;
  logic   slot_open;
  grant_e grant;

  assign mon_pend  = mon_valid;
  assign fifo_pend = fifo_en & ~fifo_empty;
  assign slot_open = (state_q == ST_IDLE) & ~u_is_transmitting;
  assign grant     = pick_grant(mon_pend, fifo_pend, last_grant_q);
  assign mon_ready = slot_open & (grant == GNT_MON) & mon_pend;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    gap_d        = gap_q;
    tx_count_d   = tx_count_q;
    tx_byte_d    = tx_byte_q;
    transmit_d   = 1'b0;
    fifo_read_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (slot_open && (mon_pend || fifo_pend)) begin
          tx_byte_d    = (grant == GNT_MON) ? mon_byte : fifo_data;
          transmit_d   = 1'b1;
          fifo_read_d  = (grant == GNT_FIFO);
          last_grant_d = grant;
          tx_count_d   = tx_count_q + CNT_WIDTH'(1);
          gap_d        = GAP_LOAD;
          state_d      = ST_GAP;
        end
      end
      ST_GAP: begin
        // The extra cycle spent seeing gap==0 makes launches GAP_CYCLES+2 apart.
        if (gap_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          gap_d = gap_q - CNT_WIDTH'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      last_grant_q <= GNT_FIFO;
      gap_q        <= '0;
      tx_count_q   <= '0;
      tx_byte_q    <= 8'h00;
      transmit_q   <= 1'b0;
      fifo_read_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      gap_q        <= gap_d;
      tx_count_q   <= tx_count_d;
      tx_byte_q    <= tx_byte_d;
      transmit_q   <= transmit_d;
      fifo_read_q  <= fifo_read_d;
    end
  end

  assign u_transmit = transmit_q;
  assign fifo_read  = fifo_read_q;
  assign u_tx_byte  = tx_byte_q;
  assign busy       = (state_q != ST_IDLE);
  assign tx_count   = tx_count_q;

endmodule

// File: tb/tb_uart_tx_pacer.sv
// Directed bench for uart_tx_pacer: reset, monitor path, FIFO drain, arbitration,
// uart-busy stall, reset mid-gap and counter wrap (on a narrow-counter instance).
module tb_uart_tx_pacer;

  logic        CLK = 1'b0;
  logic        reset;
  logic        mon_valid;
  logic [7:0]  mon_byte;
  logic        mon_ready;
  logic        fifo_en;
  logic        fifo_empty;
  logic [7:0]  fifo_data;
  logic        fifo_read;
  logic        u_is_transmitting;
  logic        u_transmit;
  logic [7:0]  u_tx_byte;
  logic        busy;
  logic [15:0] tx_count;

  logic        w_reset;
  logic        w_mon_valid;
  logic        w_mon_ready;
  logic        w_fifo_read;
  logic        w_u_transmit;
  logic [7:0]  w_u_tx_byte;
  logic        w_busy;
  logic [7:0]  w_tx_count;

  always #5 CLK = ~CLK;

  uart_tx_pacer #(.GAP_CYCLES(4), .CNT_WIDTH(16)) dut (
    .CLK(CLK), .reset(reset),
    .mon_valid(mon_valid), .mon_byte(mon_byte), .mon_ready(mon_ready),
    .fifo_en(fifo_en), .fifo_empty(fifo_empty), .fifo_data(fifo_data), .fifo_read(fifo_read),
    .u_is_transmitting(u_is_transmitting), .u_transmit(u_transmit), .u_tx_byte(u_tx_byte),
    .busy(busy), .tx_count(tx_count)
  );

  // Narrow counter and zero gap so the wrap is reachable in a few hundred cycles.
  uart_tx_pacer #(.GAP_CYCLES(0), .CNT_WIDTH(8)) dut_wrap (
    .CLK(CLK), .reset(w_reset),
    .mon_valid(w_mon_valid), .mon_byte(8'h5A), .mon_ready(w_mon_ready),
    .fifo_en(1'b0), .fifo_empty(1'b1), .fifo_data(8'h00), .fifo_read(w_fifo_read),
    .u_is_transmitting(1'b0), .u_transmit(w_u_transmit), .u_tx_byte(w_u_tx_byte),
    .busy(w_busy), .tx_count(w_tx_count)
  );

  // First-word-fall-through FIFO model: bench pushes at tail, pop strobe advances head.
  logic [7:0] fifo_mem [16];
  logic [3:0] head = '0;
  logic [3:0] tail = '0;
  assign fifo_empty = (head == tail);
  assign fifo_data  = fifo_mem[head];

  int         cyc = 0;
  int         log_n = 0;
  int         rd_count = 0;
  logic [7:0] log_byte [64];
  int         log_cyc [64];

  always @(posedge CLK) begin
    cyc = cyc + 1;
    if (u_transmit && log_n < 64) begin
      log_byte[log_n] = u_tx_byte;
      log_cyc[log_n]  = cyc;
      log_n = log_n + 1;
    end
    if (fifo_read) begin
      rd_count = rd_count + 1;
      head <= head + 4'd1;
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    fifo_mem[tail] = b;
    tail = tail + 4'd1;
  endtask

  int base;
  int rd_base;

  initial begin
    reset = 1'b0; w_reset = 1'b0; w_mon_valid = 1'b0;
    mon_valid = 1'b0; mon_byte = 8'h00; fifo_en = 1'b0; u_is_transmitting = 1'b0;
    tick(2);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_strobe", 32'(u_transmit), 32'd0);
    chk("rst_fifo_read", 32'(fifo_read), 32'd0);
    chk("rst_byte", 32'(u_tx_byte), 32'h00);
    chk("rst_count", 32'(tx_count), 32'd0);
    reset = 1'b1;
    tick();

    // Monitor only
    mon_valid = 1'b1; mon_byte = 8'h41; rd_base = rd_count;
    #1;
    chk("t1_ready", 32'(mon_ready), 32'd1);
    tick();
    mon_valid = 1'b0;
    chk("t1_strobe", 32'(u_transmit), 32'd1);
    chk("t1_byte", 32'(u_tx_byte), 32'h41);
    chk("t1_count", 32'(tx_count), 32'd1);
    chk("t1_no_pop", 32'(fifo_read), 32'd0);
    tick();
    chk("t1_strobe_1cyc", 32'(u_transmit), 32'd0);
    tick(3);
    chk("t1_busy_gap", 32'(busy), 32'd1);
    tick();
    chk("t1_idle", 32'(busy), 32'd0);
    chk("t1_pops", 32'(rd_count - rd_base), 32'd0);

    // FIFO drain with 4-cycle gap: launches 6 cycles apart
    push(8'h10); push(8'h11); push(8'h12);
    fifo_en = 1'b1; base = log_n; rd_base = rd_count;
    tick(20);
    chk("t2_launches", 32'(log_n - base), 32'd3);
    chk("t2_b0", 32'(log_byte[base]), 32'h10);
    chk("t2_b1", 32'(log_byte[base+1]), 32'h11);
    chk("t2_b2", 32'(log_byte[base+2]), 32'h12);
    chk("t2_space01", 32'(log_cyc[base+1] - log_cyc[base]), 32'd6);
    chk("t2_space12", 32'(log_cyc[base+2] - log_cyc[base+1]), 32'd6);
    chk("t2_pops", 32'(rd_count - rd_base), 32'd3);
    chk("t2_idle", 32'(busy), 32'd0);
    chk("t2_count", 32'(tx_count), 32'd4);

    // Contention: strict alternation, monitor first after a FIFO win
    push(8'h55); push(8'h56);
    mon_valid = 1'b1; mon_byte = 8'hAA; base = log_n;
    tick(19);
    mon_valid = 1'b0;
    chk("t3_last_strobe", 32'(u_transmit), 32'd1);
    tick(7);
    chk("t3_launches", 32'(log_n - base), 32'd4);
    chk("t3_b0", 32'(log_byte[base]), 32'hAA);
    chk("t3_b1", 32'(log_byte[base+1]), 32'h55);
    chk("t3_b2", 32'(log_byte[base+2]), 32'hAA);
    chk("t3_b3", 32'(log_byte[base+3]), 32'h56);
    chk("t3_count", 32'(tx_count), 32'd8);

    // Uart busy stall; FIFO disabled while non-empty
    fifo_en = 1'b0; push(8'h77); rd_base = rd_count;
    mon_valid = 1'b1; mon_byte = 8'h5A;
    tick();
    chk("t4_first_byte", 32'(u_tx_byte), 32'h5A);
    u_is_transmitting = 1'b1; mon_byte = 8'h5B;
    tick();
    base = log_n;
    tick(24);
    chk("t4_no_strobe", 32'(log_n - base), 32'd0);
    chk("t4_idle_wait", 32'(busy), 32'd0);
    chk("t4_ready_blocked", 32'(mon_ready), 32'd0);
    u_is_transmitting = 1'b0;
    #1;
    chk("t4_ready", 32'(mon_ready), 32'd1);
    tick();
    mon_valid = 1'b0;
    chk("t4_strobe", 32'(u_transmit), 32'd1);
    chk("t4_byte", 32'(u_tx_byte), 32'h5B);
    tick(7);
    chk("t4_pops", 32'(rd_count - rd_base), 32'd0);
    chk("t4_count", 32'(tx_count), 32'd10);

    // Reset mid-gap, then the pending monitor byte launches right after release
    mon_valid = 1'b1; mon_byte = 8'hC3;
    tick(3);
    reset = 1'b0; mon_byte = 8'hC4;
    tick();
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_count", 32'(tx_count), 32'd0);
    chk("t5_strobe", 32'(u_transmit), 32'd0);
    reset = 1'b1;
    #1;
    chk("t5_ready", 32'(mon_ready), 32'd1);
    tick();
    mon_valid = 1'b0;
    chk("t5_relaunch", 32'(u_transmit), 32'd1);
    chk("t5_byte", 32'(u_tx_byte), 32'hC4);
    chk("t5_count1", 32'(tx_count), 32'd1);

    // Counter wrap on the 8-bit instance: one launch every 2 cycles
    w_reset = 1'b1; w_mon_valid = 1'b1;
    tick(509);
    chk("wrap_pre", 32'(w_tx_count), 32'd255);
    tick(2);
    chk("wrap_strobe", 32'(w_u_transmit), 32'd1);
    chk("wrap_zero", 32'(w_tx_count), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
